// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared opcode values, 5-bit state encodings, control-word field
// layout and mux codes for the multicycle controller and its decoder.
// Latency: n/a (declarations only). Backpressure: n/a.
package mc_ctrl_pkg;

  typedef logic [4:0] state_t;

  // Opcodes: low 6 bits of op_code
  localparam logic [5:0] OP_ADD    = 6'd0;
  localparam logic [5:0] OP_AND    = 6'd1;
  localparam logic [5:0] OP_SUB    = 6'd2;
  localparam logic [5:0] OP_ANDI   = 6'd3;
  localparam logic [5:0] OP_ADDI   = 6'd4;
  localparam logic [5:0] OP_LW     = 6'd5;
  localparam logic [5:0] OP_LW_POI = 6'd6;
  localparam logic [5:0] OP_SW     = 6'd7;
  localparam logic [5:0] OP_BGT    = 6'd8;
  localparam logic [5:0] OP_BLT    = 6'd9;
  localparam logic [5:0] OP_BEQ    = 6'd10;
  localparam logic [5:0] OP_BNE    = 6'd11;
  localparam logic [5:0] OP_J      = 6'd12;
  localparam logic [5:0] OP_CALL   = 6'd13;
  localparam logic [5:0] OP_RET    = 6'd14;
  localparam logic [5:0] OP_PUSH   = 6'd15;
  localparam logic [5:0] OP_POP    = 6'd32;

  // State encodings
  localparam state_t ST_FETCH    = 5'd0;
  localparam state_t ST_DECODE   = 5'd1;
  localparam state_t ST_R_EX     = 5'd2;
  localparam state_t ST_ALU_WB   = 5'd3;
  localparam state_t ST_ADDI_EX  = 5'd4;
  localparam state_t ST_ANDI_EX  = 5'd5;
  localparam state_t ST_MEM_ADDR = 5'd6;
  localparam state_t ST_SW       = 5'd7;
  localparam state_t ST_LW_RD    = 5'd8;
  localparam state_t ST_LW_WB    = 5'd9;
  localparam state_t ST_LWPOI_WB = 5'd10;
  localparam state_t ST_BGT      = 5'd11;
  localparam state_t ST_BLT      = 5'd12;
  localparam state_t ST_BEQ      = 5'd13;
  localparam state_t ST_BNE      = 5'd14;
  localparam state_t ST_J        = 5'd15;
  localparam state_t ST_PUSH     = 5'd16;
  localparam state_t ST_PUSH_WR  = 5'd17;
  localparam state_t ST_RET      = 5'd18;
  localparam state_t ST_RET_PC   = 5'd19;
  localparam state_t ST_POP      = 5'd20;
  localparam state_t ST_POP_WB   = 5'd21;
  localparam state_t ST_CALL     = 5'd22;
  localparam state_t ST_CALL_WR  = 5'd23;
  localparam state_t ST_ERR      = 5'd31;

  // Control-word bit offsets (2-bit fields use +: 2)
  localparam int unsigned CW_IORD    = 0;
  localparam int unsigned CW_MEMRD   = 1;
  localparam int unsigned CW_MEMWR   = 2;
  localparam int unsigned CW_IRWR    = 3;
  localparam int unsigned CW_REGWR1  = 4;
  localparam int unsigned CW_REGWR2  = 5;
  localparam int unsigned CW_ALUSRCA = 6;
  localparam int unsigned CW_ALUSRCB = 7;
  localparam int unsigned CW_ALUOP   = 9;
  localparam int unsigned CW_PCSRC   = 11;
  localparam int unsigned CW_PCWR    = 13;
  localparam int unsigned CW_BGT     = 14;
  localparam int unsigned CW_BLT     = 15;
  localparam int unsigned CW_BEQ     = 16;
  localparam int unsigned CW_BNE     = 17;
  localparam int unsigned CW_STACK   = 18;
  localparam int unsigned CW_USED    = 20;

  localparam logic [1:0] ALUOP_ANDI  = 2'b00;
  localparam logic [1:0] ALUOP_ADD   = 2'b01;
  localparam logic [1:0] ALUOP_CMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_STACK  = 2'b11;

  localparam logic [1:0] STACK_PUSH  = 2'b01;
  localparam logic [1:0] STACK_POP   = 2'b10;

  // States that talk to memory and therefore wait on mem_ready
  function automatic logic is_mem_state(input state_t s);
    case (s)
      ST_FETCH, ST_SW, ST_LW_RD, ST_PUSH_WR, ST_RET, ST_RET_PC,
      ST_POP, ST_POP_WB, ST_CALL_WR: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  // Final state of each instruction path
  function automatic logic is_last_state(input state_t s);
    case (s)
      ST_ALU_WB, ST_SW, ST_LW_WB, ST_LWPOI_WB, ST_BGT, ST_BLT, ST_BEQ,
      ST_BNE, ST_J, ST_PUSH_WR, ST_RET_PC, ST_POP_WB, ST_CALL_WR: return 1'b1;
      default:                                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational map from a state (and opcode low bits) to the
// datapath control word. Latency: 0 cycles. Backpressure: none.
// Ports: nxt_state (state being entered), op_sel (op_code[1:0]), ctrl_word.
// PCWrite/IRWrite are produced unqualified; the FSM masks them while memory stalls.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CWW = 24
) (
  input  state_t         nxt_state,
  input  logic [1:0]     op_sel,
  output logic [CWW-1:0] ctrl_word
);

  logic [CW_USED-1:0] w;

  always_comb begin
    w = '0;
    w[CW_ALUOP +: 2] = ALUOP_ADD;
    case (nxt_state)
      ST_FETCH: begin
        w[CW_MEMRD] = 1'b1;
        w[CW_IRWR]  = 1'b1;
        w[CW_PCWR]  = 1'b1;
        w[CW_ALUSRCB +: 2] = SRCB_FOUR;
        w[CW_PCSRC +: 2]   = PCSRC_ALU;
      end
      ST_DECODE: w[CW_ALUSRCB +: 2] = SRCB_IMM_SH;
      ST_R_EX: begin
        w[CW_ALUSRCA] = 1'b1;
        w[CW_ALUSRCB +: 2] = SRCB_REG;
        w[CW_ALUOP +: 2]   = op_sel;
      end
      ST_ALU_WB, ST_LW_WB: w[CW_REGWR1] = 1'b1;
      ST_ADDI_EX, ST_MEM_ADDR: begin
        w[CW_ALUSRCA] = 1'b1;
        w[CW_ALUSRCB +: 2] = SRCB_IMM;
      end
      ST_ANDI_EX: begin
        w[CW_ALUSRCA] = 1'b1;
        w[CW_ALUSRCB +: 2] = SRCB_IMM;
        w[CW_ALUOP +: 2]   = ALUOP_ANDI;
      end
      ST_SW: begin
        w[CW_IORD]  = 1'b1;
        w[CW_MEMWR] = 1'b1;
      end
      ST_LW_RD: begin
        w[CW_IORD]  = 1'b1;
        w[CW_MEMRD] = 1'b1;
      end
      // Post-increment load also writes the bumped pointer back
      ST_LWPOI_WB: begin
        w[CW_REGWR1] = 1'b1;
        w[CW_REGWR2] = 1'b1;
      end
      ST_BGT, ST_BLT, ST_BEQ, ST_BNE: begin
        w[CW_ALUSRCA] = 1'b1;
        w[CW_ALUSRCB +: 2] = SRCB_REG;
        w[CW_ALUOP +: 2]   = ALUOP_CMP;
        w[CW_PCSRC +: 2]   = PCSRC_ALUOUT;
        w[CW_BGT] = (nxt_state == ST_BGT);
        w[CW_BLT] = (nxt_state == ST_BLT);
        w[CW_BEQ] = (nxt_state == ST_BEQ);
        w[CW_BNE] = (nxt_state == ST_BNE);
      end
      ST_J: begin
        w[CW_PCSRC +: 2] = PCSRC_JUMP;
        w[CW_PCWR] = 1'b1;
      end
      ST_PUSH: w[CW_STACK +: 2] = STACK_PUSH;
      ST_PUSH_WR, ST_CALL_WR: begin
        w[CW_IORD]   = 1'b1;
        w[CW_MEMWR]  = 1'b1;
        w[CW_REGWR2] = 1'b1;
        w[CW_STACK +: 2] = STACK_PUSH;
      end
      ST_RET, ST_POP: begin
        w[CW_IORD]  = 1'b1;
        w[CW_MEMRD] = 1'b1;
        w[CW_STACK +: 2] = STACK_POP;
      end
      ST_RET_PC: begin
        w[CW_IORD]   = 1'b1;
        w[CW_MEMRD]  = 1'b1;
        w[CW_REGWR2] = 1'b1;
        w[CW_PCWR]   = 1'b1;
        w[CW_PCSRC +: 2] = PCSRC_STACK;
        w[CW_STACK +: 2] = STACK_POP;
      end
      ST_POP_WB: begin
        w[CW_IORD]   = 1'b1;
        w[CW_MEMRD]  = 1'b1;
        w[CW_REGWR1] = 1'b1;
        w[CW_REGWR2] = 1'b1;
        w[CW_STACK +: 2] = STACK_POP;
      end
      ST_CALL: begin
        w[CW_PCSRC +: 2] = PCSRC_JUMP;
        w[CW_PCWR] = 1'b1;
        w[CW_STACK +: 2] = STACK_PUSH;
      end
      default: w = '0;  // ERR and unused encodings drive nothing
    endcase
    ctrl_word = CWW'(w);
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle CPU control FSM with mem_ready handshake, timeout trap,
// illegal-opcode pulse and retire strobe. Latency: ctrl_word registered, aligned with state.
// Backpressure: memory states hold (MemRead/MemWrite kept high) until mem_ready; trap after MEM_TIMEOUT.
// Ports: clk, rst (sync, active-high), op_code, mem_ready -> ctrl_word, state, busy,
//   retire, illegal_op, mem_timeout (sticky), retire_cnt/stall_cnt (MC_CTRL_PERF_EN only).
// Build option: define MC_CTRL_PERF_EN to add the wrapping retire/stall counters.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned OPW         = 6,
  parameter int unsigned CWW         = 24,
  parameter int unsigned MEM_TIMEOUT = 255
`ifdef MC_CTRL_PERF_EN
  ,
  parameter int unsigned CNTW        = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  op_code,
  input  logic            mem_ready,
  output logic [CWW-1:0]  ctrl_word,
  output logic [4:0]      state,
  output logic            busy,
  output logic            retire,
  output logic            illegal_op,
  output logic            mem_timeout
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNTW-1:0] retire_cnt,
  output logic [CNTW-1:0] stall_cnt
`endif
);

  // Wait counter holds 0..MEM_TIMEOUT-1; the last value with no ready traps
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t         state_q, state_d;
  logic [7:0]     wait_q, wait_d;
  logic [CWW-1:0] cw_q, cw_d;
  logic           timeout_q, timeout_d;
  logic [5:0]     op_lo;
  logic           op_hi_nz;
  logic           mem_wait;
  logic           timeout_hit;
  logic           illegal;

  assign op_lo = op_code[5:0];

  if (OPW > 6) begin : g_op_hi
    assign op_hi_nz = |op_code[OPW-1:6];
  end else begin : g_no_op_hi
    assign op_hi_nz = 1'b0;
  end

  assign mem_wait    = is_mem_state(state_q) & ~mem_ready;
  assign timeout_hit = mem_wait & (wait_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      ST_FETCH: if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (op_hi_nz) begin
          illegal = 1'b1;
          state_d = ST_FETCH;
        end else begin
          case (op_lo)
            OP_ADD, OP_AND, OP_SUB:   state_d = ST_R_EX;
            OP_ANDI:                  state_d = ST_ANDI_EX;
            OP_ADDI:                  state_d = ST_ADDI_EX;
            OP_LW, OP_LW_POI, OP_SW:  state_d = ST_MEM_ADDR;
            OP_BGT:                   state_d = ST_BGT;
            OP_BLT:                   state_d = ST_BLT;
            OP_BEQ:                   state_d = ST_BEQ;
            OP_BNE:                   state_d = ST_BNE;
            OP_J:                     state_d = ST_J;
            OP_CALL:                  state_d = ST_CALL;
            OP_RET:                   state_d = ST_RET;
            OP_PUSH:                  state_d = ST_PUSH;
            OP_POP:                   state_d = ST_POP;
            default: begin
              illegal = 1'b1;
              state_d = ST_FETCH;
            end
          endcase
        end
      end
      ST_R_EX, ST_ADDI_EX, ST_ANDI_EX: state_d = ST_ALU_WB;
      ST_MEM_ADDR: state_d = (op_lo == OP_SW) ? ST_SW : ST_LW_RD;
      ST_LW_RD:
        if (mem_ready) state_d = (op_lo == OP_LW_POI) ? ST_LWPOI_WB : ST_LW_WB;
      ST_PUSH: state_d = ST_PUSH_WR;
      ST_CALL: state_d = ST_CALL_WR;
      ST_RET:  if (mem_ready) state_d = ST_RET_PC;
      ST_POP:  if (mem_ready) state_d = ST_POP_WB;
      ST_SW, ST_PUSH_WR, ST_RET_PC, ST_POP_WB, ST_CALL_WR:
        if (mem_ready) state_d = ST_FETCH;
      ST_ERR:  state_d = ST_ERR;
      default: state_d = ST_FETCH;
    endcase
    if (timeout_hit) state_d = ST_ERR;
  end

  // Counter only runs while parked in the same memory state; any move reloads it
  always_comb begin
    wait_d    = 8'd0;
    timeout_d = timeout_q | timeout_hit;
    if (mem_wait && (state_d == state_q)) wait_d = wait_q + 8'd1;
  end

  mc_ctrl_decode #(.CWW(CWW)) u_decode (
    .nxt_state (state_d),
    .op_sel    (op_code[1:0]),
    .ctrl_word (cw_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      wait_q    <= 8'd0;
      cw_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cw_q      <= cw_d;
      timeout_q <= timeout_d;
    end
  end

  // PC/IR updates must only happen on the cycle memory actually delivers
  always_comb begin
    ctrl_word = cw_q;
    if (mem_wait) begin
      ctrl_word[CW_PCWR] = 1'b0;
      ctrl_word[CW_IRWR] = 1'b0;
    end
  end

  assign state       = state_q;
  assign busy        = (state_q != ST_FETCH);
  assign retire      = is_last_state(state_q) & (~is_mem_state(state_q) | mem_ready);
  assign illegal_op  = illegal;
  assign mem_timeout = timeout_q;

`ifdef MC_CTRL_PERF_EN
  logic [CNTW-1:0] retire_cnt_q, retire_cnt_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    retire_cnt_d = retire_cnt_q + CNTW'(retire);
    stall_cnt_d  = stall_cnt_q + CNTW'(mem_wait);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
  assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed per-cycle vectors for mc_ctrl_fsm (MEM_TIMEOUT=4).
// Each record gives one cycle's inputs and the outputs expected during that cycle.
// Perf counter checks are compiled in when MC_CTRL_PERF_EN is defined.
module tb_mc_ctrl_fsm;

  localparam logic [5:0] O_ADD = 6'd0,  O_SUB = 6'd2,  O_LW = 6'd5,  O_SW = 6'd7;
  localparam logic [5:0] O_BEQ = 6'd10, O_CALL = 6'd13, O_RET = 6'd14, O_PUSH = 6'd15;
  localparam logic [5:0] O_BAD = 6'h3F;

  localparam logic [23:0] MR  = 24'h000002, MW  = 24'h000004, IRW = 24'h000008;
  localparam logic [23:0] RW1 = 24'h000010, AOP = 24'h000600, A01 = 24'h000200;
  localparam logic [23:0] A10 = 24'h000400, PCW = 24'h002000, BEQ = 24'h010000;
  localparam logic [23:0] ALL = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op_code;
  logic        mem_ready;
  logic [23:0] ctrl_word;
  logic [4:0]  state;
  logic        busy, retire, illegal_op, mem_timeout;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] retire_cnt, stall_cnt;
`endif

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.OPW(6), .CWW(24), .MEM_TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .op_code     (op_code),
    .mem_ready   (mem_ready),
    .ctrl_word   (ctrl_word),
    .state       (state),
    .busy        (busy),
    .retire      (retire),
    .illegal_op  (illegal_op),
    .mem_timeout (mem_timeout)
`ifdef MC_CTRL_PERF_EN
    ,
    .retire_cnt  (retire_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic [4:0]  st;
    logic        ret;
    logic        ill;
    logic        to;
    logic [23:0] mask;
    logic [23:0] cw;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t v(input logic r, input logic [5:0] op, input logic mr,
                             input logic [4:0] st, input logic ret, input logic ill,
                             input logic to, input logic [23:0] mask, input logic [23:0] cw);
    vec_t t;
    t.rst = r; t.op = op; t.mr = mr; t.st = st; t.ret = ret; t.ill = ill;
    t.to = to; t.mask = mask; t.cw = cw;
    return t;
  endfunction

  function automatic bit tb_is_mem(input logic [4:0] s);
    return s inside {5'd0, 5'd7, 5'd8, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd23};
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then check that cycle's outputs
  task automatic run_vec(input vec_t t, input int idx);
    @(negedge clk);
    rst = t.rst; op_code = t.op; mem_ready = t.mr;
    #1;
    chk("state",       idx, 32'(state),       32'(t.st));
    chk("busy",        idx, 32'(busy),        32'(t.st != 5'd0));
    chk("retire",      idx, 32'(retire),      32'(t.ret));
    chk("illegal_op",  idx, 32'(illegal_op),  32'(t.ill));
    chk("mem_timeout", idx, 32'(mem_timeout), 32'(t.to));
    chk("ctrl_word",   idx, 32'(ctrl_word & t.mask), 32'(t.cw));
  endtask

  initial begin
    int exp_ret;
    int exp_stall;
    rst = 1'b1; op_code = 6'd0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    // ADD, all ready: 0,1,2,3 with ALUOp=00 in 2 and retire in 3
    tbl.push_back(v(0, O_ADD, 1,  0, 0, 0, 0, ALL, 24'h0));
    tbl.push_back(v(0, O_ADD, 1,  1, 0, 0, 0, AOP | MR | PCW, A01));
    tbl.push_back(v(0, O_ADD, 1,  2, 0, 0, 0, AOP | RW1, 24'h0));
    tbl.push_back(v(0, O_ADD, 1,  3, 1, 0, 0, AOP | RW1, A01 | RW1));
    // SUB: ALUOp follows op[1:0]=10
    tbl.push_back(v(0, O_SUB, 1,  0, 0, 0, 0, MR | IRW | PCW, MR | IRW | PCW));
    tbl.push_back(v(0, O_SUB, 1,  1, 0, 0, 0, AOP, A01));
    tbl.push_back(v(0, O_SUB, 1,  2, 0, 0, 0, AOP, A10));
    tbl.push_back(v(0, O_SUB, 1,  3, 1, 0, 0, RW1, RW1));
    // LW: three stalled cycles in 8 (one short of the trap), MemRead held 4 cycles
    tbl.push_back(v(0, O_LW,  1,  0, 0, 0, 0, MR, MR));
    tbl.push_back(v(0, O_LW,  1,  1, 0, 0, 0, MR, 24'h0));
    tbl.push_back(v(0, O_LW,  0,  6, 0, 0, 0, MR | MW, 24'h0));
    tbl.push_back(v(0, O_LW,  0,  8, 0, 0, 0, MR | PCW, MR));
    tbl.push_back(v(0, O_LW,  0,  8, 0, 0, 0, MR | PCW, MR));
    tbl.push_back(v(0, O_LW,  0,  8, 0, 0, 0, MR | PCW, MR));
    tbl.push_back(v(0, O_LW,  1,  8, 0, 0, 0, MR, MR));
    tbl.push_back(v(0, O_LW,  1,  9, 1, 0, 0, MR | RW1, RW1));
    // Illegal opcode: pulse in DECODE, back to FETCH, no retire
    tbl.push_back(v(0, O_BAD, 1,  0, 0, 0, 0, MR, MR));
    tbl.push_back(v(0, O_BAD, 1,  1, 0, 1, 0, AOP, A01));
    // CALL then RET: PCWrite in 22 and 19
    tbl.push_back(v(0, O_CALL, 1, 0, 0, 0, 0, MR | IRW | PCW, MR | IRW | PCW));
    tbl.push_back(v(0, O_CALL, 1, 1, 0, 0, 0, MR, 24'h0));
    tbl.push_back(v(0, O_CALL, 1, 22, 0, 0, 0, PCW | MR, PCW));
    tbl.push_back(v(0, O_CALL, 1, 23, 1, 0, 0, MW | PCW, MW));
    tbl.push_back(v(0, O_RET,  1, 0, 0, 0, 0, MR, MR));
    tbl.push_back(v(0, O_RET,  1, 1, 0, 0, 0, MR, 24'h0));
    tbl.push_back(v(0, O_RET,  1, 18, 0, 0, 0, MR | PCW, MR));
    tbl.push_back(v(0, O_RET,  1, 19, 1, 0, 0, MR | PCW, MR | PCW));
    // FETCH stall: PC/IR writes suppressed until ready
    tbl.push_back(v(0, O_PUSH, 0, 0, 0, 0, 0, MR | IRW | PCW, MR));
    tbl.push_back(v(0, O_PUSH, 1, 0, 0, 0, 0, MR | IRW | PCW, MR | IRW | PCW));
    // PUSH: terminal memory state retires only on the ready cycle
    tbl.push_back(v(0, O_PUSH, 1, 1, 0, 0, 0, MW, 24'h0));
    tbl.push_back(v(0, O_PUSH, 0, 16, 0, 0, 0, MW, 24'h0));
    tbl.push_back(v(0, O_PUSH, 0, 17, 0, 0, 0, MW, MW));
    tbl.push_back(v(0, O_PUSH, 1, 17, 1, 0, 0, MW, MW));
    // BEQ: op[1:0]=10 -> state 13, ALUOp=10, BEQ condition bit
    tbl.push_back(v(0, O_BEQ, 1,  0, 0, 0, 0, MR, MR));
    tbl.push_back(v(0, O_BEQ, 1,  1, 0, 0, 0, AOP, A01));
    tbl.push_back(v(0, O_BEQ, 1, 13, 1, 0, 0, AOP | PCW | BEQ, A10 | BEQ));
    tbl.push_back(v(0, O_ADD, 0,  0, 0, 0, 0, MR | PCW, MR));

    foreach (tbl[i]) run_vec(tbl[i], i);

    exp_ret = 0;
    exp_stall = 0;
    foreach (tbl[i]) begin
      if (tbl[i].ret) exp_ret++;
      if (!tbl[i].rst && !tbl[i].mr && tb_is_mem(tbl[i].st)) exp_stall++;
    end
    @(negedge clk);
    #1;
`ifdef MC_CTRL_PERF_EN
    chk("retire_cnt", 900, retire_cnt, 32'(exp_ret));
    chk("stall_cnt",  901, stall_cnt,  32'(exp_stall));
`endif

    // SW never ready: trap after the 4th wait cycle, sticky until rst
    run_vec(v(0, O_SW, 1,  0, 0, 0, 0, MR, MR), 100);
    run_vec(v(0, O_SW, 1,  1, 0, 0, 0, MW, 24'h0), 101);
    run_vec(v(0, O_SW, 0,  6, 0, 0, 0, MW, 24'h0), 102);
    for (int k = 0; k < 4; k++)
      run_vec(v(0, O_SW, 0, 7, 0, 0, 0, MW | PCW, MW), 103 + k);
    run_vec(v(0, O_SW, 1, 31, 0, 0, 1, ALL, 24'h0), 107);
    run_vec(v(0, O_SW, 0, 31, 0, 0, 1, ALL, 24'h0), 108);
    run_vec(v(1, O_SW, 0, 31, 0, 0, 1, ALL, 24'h0), 109);
    run_vec(v(0, O_LW, 1,  0, 0, 0, 0, ALL, 24'h0), 110);

    // rst mid-wait in state 8
    run_vec(v(0, O_LW, 1,  1, 0, 0, 0, MR, 24'h0), 120);
    run_vec(v(0, O_LW, 0,  6, 0, 0, 0, MR, 24'h0), 121);
    run_vec(v(0, O_LW, 0,  8, 0, 0, 0, MR, MR), 122);
    run_vec(v(1, O_LW, 0,  8, 0, 0, 0, MR, MR), 123);
    run_vec(v(0, O_LW, 0,  0, 0, 0, 0, ALL, 24'h0), 124);
`ifdef MC_CTRL_PERF_EN
    chk("retire_cnt_rst", 125, retire_cnt, 32'd0);
    chk("stall_cnt_rst",  126, stall_cnt,  32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
